cp0_exc_sequencer: RTL and testbench

- Multi-cycle controller that sequences CP0 register accesses for exception entry (SYSCALL/BREAK/TEQ) and ERET in the multi-cycle MIPS core.
- Drives the CP0 read-address selects (RD / STATUS / EPC one-hot) and the CP0 write port.
- Issues a PC redirect to the main control FSM when the sequence finishes.
- Sits between the main control unit and the CP0 register file.

---
 rtl/cp0_exc_sequencer_if.sv | 28 ++
 rtl/cp0_exc_sequencer.sv | 120 ++++++++++++
 tb/tb_cp0_exc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_sequencer_if.sv
// cp0_exc_sequencer_if: request, CP0 access and redirect signals of the exception sequencer
interface cp0_exc_sequencer_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret_req;
  logic [31:0] pc_cur;
  logic [31:0] cp0_rdata;
  logic        muxt_cp0_r_rd;
  logic        muxt_cp0_r_satus;
  logic        muxt_cp0_r_epc;
  logic        cp0_we;
  logic [4:0]  cp0_w_addr;
  logic [31:0] cp0_w_data;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy;
  logic        done;
  modport master (
    output exc_req, exc_code, eret_req, pc_cur, cp0_rdata,
    input  muxt_cp0_r_rd, muxt_cp0_r_satus, muxt_cp0_r_epc, cp0_we, cp0_w_addr,
           cp0_w_data, pc_redirect, pc_target, busy, done
  );
  modport slave (
    input  exc_req, exc_code, eret_req, pc_cur, cp0_rdata,
    output muxt_cp0_r_rd, muxt_cp0_r_satus, muxt_cp0_r_epc, cp0_we, cp0_w_addr,
           cp0_w_data, pc_redirect, pc_target, busy, done
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer: sequences CP0 accesses for exception entry and ERET, then redirects the PC
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR      = 32'h0040_0004,
  parameter logic [4:0]  CP0_ADDR_STATUS = 5'd12,
  parameter logic [4:0]  CP0_ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  CP0_ADDR_EPC    = 5'd14
) (
  input logic clk,
  input logic rst_n,
  cp0_exc_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, E_RSTAT, E_WSTAT, E_WCAUSE, E_WEPC, E_DONE, MASKED,
    R_REPC, R_RSTAT, R_WSTAT, R_DONE
  } state_t;
  state_t      state;
  logic [4:0]  code_l;
  logic [31:0] pc_l;
  logic [31:0] epc_l;
  // State walk with outputs registered for the state being entered; Status read data
  // is shifted straight into the write register on the edge that leaves the read state.
  // Non-read states park the read mux on Status so the selects stay one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      code_l               <= '0;
      pc_l                 <= '0;
      epc_l                <= '0;
      bus.muxt_cp0_r_rd    <= 1'b1;
      bus.muxt_cp0_r_satus <= 1'b0;
      bus.muxt_cp0_r_epc   <= 1'b0;
      bus.cp0_we           <= 1'b0;
      bus.cp0_w_addr       <= '0;
      bus.cp0_w_data       <= '0;
      bus.pc_redirect      <= 1'b0;
      bus.pc_target        <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
    end else begin
      bus.muxt_cp0_r_rd    <= 1'b0;
      bus.muxt_cp0_r_satus <= 1'b1;
      bus.muxt_cp0_r_epc   <= 1'b0;
      bus.cp0_we           <= 1'b0;
      bus.cp0_w_addr       <= '0;
      bus.cp0_w_data       <= '0;
      bus.pc_redirect      <= 1'b0;
      bus.pc_target        <= '0;
      bus.busy             <= 1'b1;
      bus.done             <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.exc_req) begin
            state  <= E_RSTAT;
            code_l <= bus.exc_code;
            pc_l   <= bus.pc_cur;
          end else if (bus.eret_req) begin
            state                <= R_REPC;
            bus.muxt_cp0_r_satus <= 1'b0;
            bus.muxt_cp0_r_epc   <= 1'b1;
          end else begin
            bus.muxt_cp0_r_rd    <= 1'b1;
            bus.muxt_cp0_r_satus <= 1'b0;
            bus.busy             <= 1'b0;
          end
        end
        E_RSTAT: begin
          if (bus.cp0_rdata[0]) begin
            state          <= E_WSTAT;
            bus.cp0_we     <= 1'b1;
            bus.cp0_w_addr <= CP0_ADDR_STATUS;
            bus.cp0_w_data <= bus.cp0_rdata << 5;
          end else begin
            state    <= MASKED;
            bus.done <= 1'b1;
          end
        end
        E_WSTAT: begin
          state          <= E_WCAUSE;
          bus.cp0_we     <= 1'b1;
          bus.cp0_w_addr <= CP0_ADDR_CAUSE;
          bus.cp0_w_data <= {25'b0, code_l, 2'b00};
        end
        E_WCAUSE: begin
          state          <= E_WEPC;
          bus.cp0_we     <= 1'b1;
          bus.cp0_w_addr <= CP0_ADDR_EPC;
          bus.cp0_w_data <= pc_l;
        end
        E_WEPC: begin
          state           <= E_DONE;
          bus.pc_redirect <= 1'b1;
          bus.pc_target   <= EXC_VECTOR;
          bus.done        <= 1'b1;
        end
        R_REPC: begin
          state <= R_RSTAT;
          epc_l <= bus.cp0_rdata;
        end
        R_RSTAT: begin
          state          <= R_WSTAT;
          bus.cp0_we     <= 1'b1;
          bus.cp0_w_addr <= CP0_ADDR_STATUS;
          bus.cp0_w_data <= bus.cp0_rdata >> 5;
        end
        R_WSTAT: begin
          state           <= R_DONE;
          bus.pc_redirect <= 1'b1;
          bus.pc_target   <= epc_l;
          bus.done        <= 1'b1;
        end
        default: begin
          state                <= IDLE;
          bus.muxt_cp0_r_rd    <= 1'b1;
          bus.muxt_cp0_r_satus <= 1'b0;
          bus.busy             <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb_cp0_exc_sequencer: scoreboard bench with a small CP0 register model behind the sequencer
module tb_cp0_exc_sequencer;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  typedef struct {
    int          k;
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  logic [31:0] st = '0;
  logic [31:0] ep = '0;
  logic [31:0] ca = '0;
  ev_t         q[$];
  cp0_exc_sequencer_if bus ();
  cp0_exc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.cp0_rdata = bus.muxt_cp0_r_satus ? st : bus.muxt_cp0_r_epc ? ep : 32'h0;
  // CP0 register model commits writes on the clock edge
  always @(posedge clk)
    if (bus.cp0_we)
      case (bus.cp0_w_addr)
        5'd12: st <= bus.cp0_w_data;
        5'd13: ca <= bus.cp0_w_data;
        5'd14: ep <= bus.cp0_w_data;
        default: ;
      endcase
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic push(input int k, input logic [4:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.c = c;
    q.push_back(e);
  endtask
  task automatic pop_chk(input int k, input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", k, 0);
      return;
    end
    e = q.pop_front();
    chk("event_kind", k, e.k);
    chk("event_addr", {27'b0, a}, {27'b0, e.a});
    chk("event_data", d, e.d);
    chk("event_cycle", cyc, e.c);
  endtask
  // Expected events of an exception whose request is sampled on edge c+1
  task automatic push_exc(input int c, input logic [31:0] s, input logic [4:0] code, input logic [31:0] pc);
    if (s[0]) begin
      push(1, 5'd12, s << 5, c + 2);
      push(1, 5'd13, {25'b0, code, 2'b00}, c + 3);
      push(1, 5'd14, pc, c + 4);
      push(2, 5'd0, EXC_VECTOR, c + 5);
      push(3, 5'd0, 32'h0, c + 5);
    end else push(3, 5'd0, 32'h0, c + 2);
  endtask
  task automatic push_eret(input int c, input logic [31:0] e, input logic [31:0] s);
    push(1, 5'd12, s >> 5, c + 3);
    push(2, 5'd0, e, c + 4);
    push(3, 5'd0, 32'h0, c + 4);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk("done_timeout", 0, 1);
  endtask
  // Monitor: protocol invariants every cycle, events popped against the scoreboard
  always @(negedge clk) begin
    chk("sel_onehot", $countones({bus.muxt_cp0_r_rd, bus.muxt_cp0_r_satus, bus.muxt_cp0_r_epc}), 1);
    chk("wport_idle_zero", bus.cp0_we ? 32'h0 : (bus.cp0_w_data | {27'b0, bus.cp0_w_addr}), 0);
    chk("target_idle_zero", bus.pc_redirect ? 32'h0 : bus.pc_target, 0);
    if (bus.cp0_we) pop_chk(1, bus.cp0_w_addr, bus.cp0_w_data);
    if (bus.pc_redirect) pop_chk(2, 5'd0, bus.pc_target);
    if (bus.done) pop_chk(3, 5'd0, 32'h0);
  end
  initial begin
    int c;
    bus.exc_req = 1'b1;
    bus.exc_code = 5'd8;
    bus.eret_req = 1'b0;
    bus.pc_cur = 32'h0040_0100;
    st = 32'h0000_0001;
    ep = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.cp0_we, 0);
    chk("rst_sel_rd", bus.muxt_cp0_r_rd, 1);
    chk("rst_done", bus.done, 0);
    // Syscall started by releasing reset with the request already held
    c = cyc;
    push_exc(c, st, 5'd8, 32'h0040_0100);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_sel_status", bus.muxt_cp0_r_satus, 1);
    chk("rel_busy", bus.busy, 1);
    wait_done();
    bus.exc_req = 1'b0;
    @(negedge clk);
    chk("sys_status", st, 32'h20);
    chk("sys_cause", ca, 32'h20);
    chk("sys_epc", ep, 32'h0040_0100);
    chk("sys_idle", bus.busy, 0);
    // Masked teq
    st = 32'h0;
    c = cyc;
    push_exc(c, st, 5'd13, 32'h0040_0200);
    bus.exc_req = 1'b1;
    bus.exc_code = 5'd13;
    bus.pc_cur = 32'h0040_0200;
    wait_done();
    bus.exc_req = 1'b0;
    @(negedge clk);
    chk("mask_epc_kept", ep, 32'h0040_0100);
    // ERET
    st = 32'h0000_0020;
    c = cyc;
    push_eret(c, ep, st);
    bus.eret_req = 1'b1;
    wait_done();
    bus.eret_req = 1'b0;
    @(negedge clk);
    chk("eret_status", st, 32'h1);
    // Simultaneous break and ERET: exception first, ERET after DONE
    c = cyc;
    push_exc(c, st, 5'd9, 32'h0040_0300);
    push_eret(c + 6, 32'h0040_0300, st << 5);
    bus.exc_req = 1'b1;
    bus.eret_req = 1'b1;
    bus.exc_code = 5'd9;
    bus.pc_cur = 32'h0040_0300;
    wait_done();
    bus.exc_req = 1'b0;
    @(negedge clk);
    chk("both_cause", ca, 32'h24);
    wait_done();
    bus.eret_req = 1'b0;
    @(negedge clk);
    chk("both_status", st, 32'h1);
    // Reset while in E_WCAUSE
    ep = 32'h0000_1234;
    c = cyc;
    push(1, 5'd12, 32'h20, c + 2);
    bus.exc_req = 1'b1;
    bus.exc_code = 5'd8;
    bus.pc_cur = 32'h0040_0400;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    bus.exc_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sel_rd", bus.muxt_cp0_r_rd, 1);
    repeat (2) @(negedge clk);
    chk("abort_status", st, 32'h20);
    chk("abort_epc", ep, 32'h0000_1234);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
